// File: rtl/out_ctrl_pkg.sv
// out_ctrl_pkg: shared state encoding, packet length and flit field helpers
package out_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, WAIT_ACK, RELEASE} state_t;
  function automatic int flit_count(input int buff_bits);
    return 1 << buff_bits;
  endfunction
  function automatic int head_bit(input int size);
    return size - 1;
  endfunction
  function automatic int dest_lsb(input int size, input int chnl_bits);
    return size - 1 - chnl_bits;
  endfunction
endpackage

// File: rtl/out_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick searching upward from last_winner+1
module rr_arbiter #(
  parameter int PORTS = 5,
  localparam int IW = PORTS > 1 ? $clog2(PORTS) : 1
) (
  input  logic [PORTS-1:0] req,
  input  logic [IW-1:0]    last_winner,
  output logic [PORTS-1:0] gnt,
  output logic [IW-1:0]    idx
);
  logic [IW-1:0] p;
  logic found;
  // first requester after the previous winner, wrapping at PORTS-1
  always_comb begin
    gnt = '0;
    idx = '0;
    p = '0;
    found = 1'b0;
    for (int k = 1; k <= PORTS; k++) begin
      p = IW'((int'(last_winner) + k) % PORTS);
      if (!found && req[p]) begin
        found = 1'b1;
        gnt[p] = 1'b1;
        idx = p;
      end
    end
  end
endmodule

// File: rtl/out_ctrl.sv
// out_ctrl: output channel arbiter streaming one packet per grant over a 2-phase link
module out_ctrl
  import out_ctrl_pkg::*;
#(
  parameter int ID = 0,
  parameter int PORTS = 5,
  parameter int SIZE = 8,
  parameter int CHANNEL_BITS = 3,
  parameter int BUFF_BITS = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [PORTS-1:0]          rx_req,
  input  logic [PORTS*CHANNEL_BITS-1:0] rx_chnl,
  output logic [PORTS-1:0]          rx_gnt,
  output logic [BUFF_BITS-1:0]      buf_addr,
  input  logic [PORTS*SIZE-1:0]     buf_data,
  output logic                      ch_req,
  output logic [SIZE-1:0]           ch_flit,
  input  logic                      ch_ack
);
  localparam int FLIT_COUNT = flit_count(BUFF_BITS);
  localparam int IW = PORTS > 1 ? $clog2(PORTS) : 1;
  state_t state, state_n;
  logic [IW-1:0] winner, winner_n, last_winner, last_winner_n, arb_idx;
  logic [PORTS-1:0] valid, arb_gnt, rx_gnt_n;
  logic [BUFF_BITS-1:0] flit_idx, flit_idx_n;
  logic ch_req_n;
  logic [SIZE-1:0] ch_flit_n;
  // requests only count when aimed at this channel
  always_comb begin
    valid = '0;
    for (int i = 0; i < PORTS; i++)
      valid[i] = rx_req[i] && rx_chnl[i*CHANNEL_BITS +: CHANNEL_BITS] == CHANNEL_BITS'(ID);
  end
  rr_arbiter #(.PORTS(PORTS)) u_arb (
    .req(valid),
    .last_winner(last_winner),
    .gnt(arb_gnt),
    .idx(arb_idx)
  );
  assign buf_addr = flit_idx;
  // next-state: grant in IDLE, one flit per FETCH/WAIT_ACK round, drop grant in RELEASE
  always_comb begin
    state_n = state;
    winner_n = winner;
    last_winner_n = last_winner;
    rx_gnt_n = rx_gnt;
    flit_idx_n = flit_idx;
    ch_req_n = ch_req;
    ch_flit_n = ch_flit;
    case (state)
      IDLE: if (|valid) begin
        rx_gnt_n = arb_gnt;
        winner_n = arb_idx;
        flit_idx_n = '0;
        state_n = FETCH;
      end
      FETCH: begin
        ch_flit_n = buf_data[int'(winner)*SIZE +: SIZE];
        ch_req_n = ~ch_req;
        state_n = WAIT_ACK;
      end
      WAIT_ACK: if (ch_ack == ch_req) begin
        if (flit_idx == BUFF_BITS'(FLIT_COUNT - 1)) state_n = RELEASE;
        else begin
          flit_idx_n = flit_idx + 1'b1;
          state_n = FETCH;
        end
      end
      RELEASE: begin
        rx_gnt_n = '0;
        last_winner_n = winner;
        flit_idx_n = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  // state register; reset aborts any packet in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      winner <= '0;
      last_winner <= IW'(PORTS - 1);
      rx_gnt <= '0;
      flit_idx <= '0;
      ch_req <= 1'b0;
      ch_flit <= '0;
    end else begin
      state <= state_n;
      winner <= winner_n;
      last_winner <= last_winner_n;
      rx_gnt <= rx_gnt_n;
      flit_idx <= flit_idx_n;
      ch_req <= ch_req_n;
      ch_flit <= ch_flit_n;
    end
  end
endmodule

// File: tb/tb_out_ctrl.sv
// tb_out_ctrl: randomized self-checking bench with packet-level reference model
module tb_out_ctrl;
  localparam int ID = 2, PORTS = 5, SIZE = 8, CB = 3, BB = 3, FC = 8;
  logic clk = 0, reset = 1;
  logic [PORTS-1:0] rx_req = '0, rx_gnt;
  logic [PORTS*CB-1:0] rx_chnl = '0;
  logic [BB-1:0] buf_addr;
  logic [PORTS*SIZE-1:0] buf_data;
  logic ch_req, ch_ack = 0;
  logic [SIZE-1:0] ch_flit;
  logic [7:0] mem [PORTS][FC];
  int ack_delay = 1, n_chk = 0, n_fail = 0, last_m = PORTS - 1;
  int order [4] = '{0, 4, 0, 4};

  out_ctrl #(.ID(ID), .PORTS(PORTS), .SIZE(SIZE), .CHANNEL_BITS(CB), .BUFF_BITS(BB)) dut (
    .clk(clk), .reset(reset), .rx_req(rx_req), .rx_chnl(rx_chnl), .rx_gnt(rx_gnt),
    .buf_addr(buf_addr), .buf_data(buf_data), .ch_req(ch_req), .ch_flit(ch_flit), .ch_ack(ch_ack)
  );

  always #5 clk = ~clk;

  always_comb begin
    buf_data = '0;
    for (int i = 0; i < PORTS; i++) buf_data[i*SIZE +: SIZE] = mem[i][buf_addr];
  end

  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        ch_ack = 0;
        cnt = 0;
      end else if (ch_req !== ch_ack) begin
        cnt++;
        if (cnt >= ack_delay) begin
          ch_ack = ch_req;
          cnt = 0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_req(input int p, input int c, input logic v);
    rx_chnl[p*CB +: CB] = CB'(c);
    rx_req[p] = v;
  endtask

  function automatic int pick();
    for (int k = 1; k <= PORTS; k++) begin
      int p = (last_m + k) % PORTS;
      if (rx_req[p] && rx_chnl[p*CB +: CB] == CB'(ID)) return p;
    end
    return -1;
  endfunction

  task automatic fill_mem(input logic rnd);
    for (int p = 0; p < PORTS; p++)
      for (int a = 0; a < FC; a++) mem[p][a] = rnd ? 8'($urandom) : 8'(8'h80 + a);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_gnt"}, rx_gnt, 0);
    chk({tag, "_req"}, ch_req, 0);
    chk({tag, "_flit"}, ch_flit, 0);
    chk({tag, "_addr"}, buf_addr, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    rx_req = '0;
    last_m = PORTS - 1;
    repeat (2) @(posedge clk);
    #1 check_idle("rst");
    @(negedge clk);
    reset = 0;
  endtask

  task automatic wait_grant(input int exp, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1 cyc++;
    end while (rx_gnt == 0 && cyc < 50);
    chk("grant", rx_gnt, 32'(1) << exp);
    if (exp >= 0) rx_req[exp] = 0;
  endtask

  task automatic xfer(input int port, input int abort_at, input int late_port, output int n);
    logic lr;
    int cyc;
    bit done;
    n = 0;
    lr = ch_req;
    cyc = 0;
    done = 0;
    while (!done) begin
      @(posedge clk);
      #1 cyc++;
      if (rx_gnt == 0 || cyc > 600) done = 1;
      else begin
        chk("gnt_hold", rx_gnt, 32'(1) << port);
        if (ch_req !== lr) begin
          lr = ch_req;
          chk("flit", ch_flit, mem[port][n]);
          chk("addr", buf_addr, n);
          n++;
          if (late_port >= 0 && n == 2) set_req(late_port, ID, 1);
          if (n == abort_at) done = 1;
        end else if (ch_req !== ch_ack) begin
          chk("flit_hold", ch_flit, mem[port][n-1]);
          chk("addr_hold", buf_addr, n - 1);
        end
      end
    end
    if (abort_at < 0) last_m = port;
  endtask

  task automatic packet(input string tag, input int late_port);
    int w, cyc, n;
    w = pick();
    wait_grant(w, cyc);
    xfer(w, -1, late_port, n);
    chk({tag, "_count"}, n, FC);
    chk({tag, "_released"}, rx_gnt, 0);
    chk({tag, "_addr0"}, buf_addr, 0);
  endtask

  initial begin
    int cyc, n, w, bad, tog;
    logic lr;
    fill_mem(0);
    repeat (2) @(posedge clk);
    #1 check_idle("init");
    @(negedge clk);
    reset = 0;

    set_req(1, ID, 1);
    wait_grant(pick(), cyc);
    chk("latency", cyc, 1);
    chk("single_gnt", rx_gnt, 5'b00010);
    xfer(1, -1, -1, n);
    chk("single_count", n, FC);
    chk("single_released", rx_gnt, 0);

    set_req(3, 4, 1);
    bad = 0;
    tog = 0;
    lr = ch_req;
    repeat (20) begin
      @(posedge clk);
      #1 if (rx_gnt != 0) bad++;
      if (ch_req !== lr) tog++;
      lr = ch_req;
    end
    chk("wrongch_gnt", bad, 0);
    chk("wrongch_toggles", tog, 0);
    set_req(3, 0, 0);

    do_reset();
    fill_mem(1);
    set_req(0, ID, 1);
    set_req(4, ID, 1);
    for (int i = 0; i < 4; i++) begin
      w = pick();
      chk("fair_model", w, order[i]);
      wait_grant(w, cyc);
      xfer(w, -1, -1, n);
      chk("fair_count", n, FC);
      if (i < 3) set_req(w, ID, 1);
      else rx_req = '0;
    end

    ack_delay = 5;
    fill_mem(1);
    set_req(1, ID, 1);
    packet("slow", -1);
    ack_delay = 1;

    set_req(2, ID, 1);
    wait_grant(pick(), cyc);
    xfer(2, 3, -1, n);
    chk("abort_at", n, 3);
    reset = 1;
    #1 check_idle("async_rst");
    last_m = PORTS - 1;
    repeat (2) @(posedge clk);
    #1 check_idle("held_rst");
    @(negedge clk);
    set_req(2, ID, 1);
    reset = 0;
    packet("after_rst", -1);

    fill_mem(1);
    set_req(1, ID, 1);
    packet("late_first", 3);
    w = pick();
    chk("late_model", w, 3);
    wait_grant(w, cyc);
    chk("late_latency", cyc, 1);
    xfer(3, -1, -1, n);
    chk("late_count", n, FC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
